// File: rtl/prbs_ctrl_pkg.sv
// Shared types and constants for the PRBS31 BERT controller.
package prbs_ctrl_pkg;

    localparam int PRBS_W    = 31;
    localparam int ERR_W     = 8;
    localparam int LEN_W     = 15;
    localparam int DRAIN_CYC = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_RUN   = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    function automatic logic [LEN_W-1:0] run_len(input logic [1:0] sel);
        case (sel)
            2'd0:    run_len = 15'd256;
            2'd1:    run_len = 15'd1024;
            2'd2:    run_len = 15'd4096;
            default: run_len = 15'd16384;
        endcase
    endfunction

endpackage

// File: rtl/prbs_ctrl_len_cnt.sv
// Run-length down-counter: loads a value, decrements on request, flags zero.
module prbs_ctrl_len_cnt
    import prbs_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             zero
);

    logic [LEN_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 bit-error-rate test sequencer: seeds the generator, runs N bits, tallies checker errors.
// Optional error injection (inj_req/gen_inv) is built when PRBS_CTRL_ERR_INJECT_EN is defined.
module prbs31_bert_ctrl
    import prbs_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        len_sel,
    input  logic [7:0]        seed,
    output logic              gen_load,
    output logic [PRBS_W-1:0] gen_seed,
    output logic              gen_en,
    input  logic              chk_valid,
    input  logic              chk_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef PRBS_CTRL_ERR_INJECT_EN
    input  logic              inj_req,
    output logic              gen_inv,
`endif
    output logic [ERR_W-1:0]  err_cnt
);

    state_t           state_q, state_d;
    logic [1:0]       len_q;
    logic [7:0]       seed_q;
    logic [ERR_W-1:0] err_q;
    logic [1:0]       drain_q;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [LEN_W-1:0] cnt_val;

    // Counter holds N-1 on entry to RUN so RUN lasts exactly N cycles.
    prbs_ctrl_len_cnt u_len_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (run_len(len_q) - 1'b1),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        accept  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (cnt_zero) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (drain_q == 2'(DRAIN_CYC - 1)) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= 2'd0;
            seed_q  <= 8'd0;
            err_q   <= '0;
            drain_q <= 2'd0;
        end else if (ena) begin
            state_q <= state_d;
            if (accept) begin
                len_q  <= len_sel;
                seed_q <= seed;
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + 1'b1 : 2'd0;
            if (state_q == S_LOAD) begin
                err_q <= '0;
            end else if ((state_q == S_RUN || state_q == S_DRAIN) && chk_valid && chk_err
                         && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

`ifdef PRBS_CTRL_ERR_INJECT_EN
    logic inj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
        end else if (ena) begin
            inj_q <= inj_req;
        end
    end

    assign gen_inv = ena && (state_q == S_RUN) && inj_req && !inj_q;
`endif

    assign gen_load = ena && (state_q == S_LOAD);
    assign gen_en   = ena && (state_q == S_RUN);
    assign gen_seed = {{(PRBS_W - 9){1'b0}}, 1'b1, seed_q};
    assign busy     = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign pass     = done && (err_q == '0);
    assign err_cnt  = err_q;

endmodule

// File: doc/prbs31_bert_ctrl.md
PRBS31_BERT_CTRL -- requirements
Module: prbs31_bert_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port ena, input, 1 bit: block enable; low freezes all state.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a test.
REQ-005 SHALL have port abort, input, 1 bit: cancel the running test.
REQ-006 SHALL have port len_sel, input, 2 bits: run length N = 256, 1024, 4096 or 16384 bits for 0..3.
REQ-007 SHALL have port seed, input, 8 bits: user seed byte.
REQ-008 SHALL have port gen_load, output, 1 bit: load pulse to the PRBS31 generator.
REQ-009 SHALL have port gen_seed, output, 31 bits: seed to the generator, equal to {23'd1, seed}, never zero.
REQ-010 SHALL have port gen_en, output, 1 bit: generator advance, one bit per cycle.
REQ-011 SHALL have port chk_valid, input, 1 bit: the checker result is valid this cycle.
REQ-012 SHALL have port chk_err, input, 1 bit: checker mismatch flag, qualified by chk_valid.
REQ-013 SHALL have ports busy, done and pass, outputs, 1 bit each: status flags.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating error count.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-016 SHALL transition IDLE->LOAD on start; LOAD lasts 1 cycle and asserts gen_load with gen_seed valid; it also clears err_cnt, done and pass.
REQ-017 SHALL latch len_sel and seed when start is accepted; later changes SHALL NOT affect the running test.
REQ-018 SHALL hold gen_en=1 for exactly N cycles in RUN, then go to DRAIN; gen_en SHALL be 0 in every other state.
REQ-019 SHALL stay in DRAIN for DRAIN_CYC=2 cycles to absorb checker latency, then go to DONE.
REQ-020 SHALL increment err_cnt on every cycle in RUN or DRAIN with chk_valid&chk_err, saturating at 255.
REQ-021 SHALL, in DONE, assert done=1 and pass=(err_cnt==0), hold both until the next accepted start, and accept start from DONE as from IDLE.
REQ-022 SHALL assert busy in LOAD, RUN and DRAIN only.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL, when abort is seen in LOAD, RUN or DRAIN, go to IDLE next cycle with gen_en=0, done=0 and pass=0, leaving err_cnt held.
REQ-025 SHALL give abort priority when start and abort are high in the same cycle.
REQ-026 SHALL, while ena=0, hold state, counters and flags, force gen_en=0 and gen_load=0, and ignore start, abort and chk_valid; a frozen RUN SHALL resume with its remaining count intact.

Reset
REQ-027 SHALL on rst_n=0 enter IDLE with gen_load, gen_en, busy, done and pass at 0, err_cnt at 0, the length counter at 0, and gen_seed at {23'd1, 8'd0}.
REQ-028 SHALL abandon a test immediately when reset asserts mid-test, with no further gen_en pulses.

Configuration
REQ-029 SHALL, with PRBS_CTRL_ERR_INJECT_EN defined, add input inj_req (1 bit) and output gen_inv (1 bit).
REQ-030 SHALL, with PRBS_CTRL_ERR_INJECT_EN defined, pulse gen_inv for one cycle on a rising edge of inj_req during RUN, inverting one generated bit.
REQ-031 SHALL, without PRBS_CTRL_ERR_INJECT_EN, omit both inj_req and gen_inv; all other behaviour is identical.

Structure
REQ-032 SHALL take the following from shared package prbs_ctrl_pkg: the state enum, PRBS_W=31, ERR_W=8, DRAIN_CYC=2, and the len_sel->N lookup.
REQ-033 SHALL place the 15-bit run-length down-counter (load, decrement, zero flag) in sub-module prbs_ctrl_len_cnt.

Verification
REQ-034 SHALL cover: seed=8'hA5, len_sel=0, start, chk_err=0 -> gen_load 1 cycle with gen_seed=31'h000001A5, then exactly 256 gen_en cycles, then done=1, pass=1, err_cnt=0.
REQ-035 SHALL cover: len_sel=1 with 3 chk_valid&chk_err pulses during RUN -> 1024 gen_en cycles, done=1, pass=0, err_cnt=3.
REQ-036 SHALL cover: len_sel=3 with chk_err=1 on every valid cycle -> err_cnt saturates at 255 and does not wrap.
REQ-037 SHALL cover: abort at RUN cycle 100, then start and abort together -> IDLE, gen_en=0, done=0; the simultaneous start is ignored.
REQ-038 SHALL cover: ena=0 for 50 cycles mid-RUN, len_sel=0 -> gen_en count still totals 256 and the state is held throughout.
REQ-039 SHALL cover: with PRBS_CTRL_ERR_INJECT_EN, an inj_req pulse during RUN -> exactly one gen_inv cycle; when looped through the checker, err_cnt=1 and pass=0.
